dsrlzr_rx: RTL and testbench

//  Serial-to-parallel receiver (deserializer) downstream of the 4-bit PISO serializer.

---
 rtl/dsrlzr_rx_if.sv | 21 ++
 rtl/dsrlzr_rx.sv | 99 +++++++++
 tb/tb_dsrlzr_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dsrlzr_rx_if.sv
// rtl/dsrlzr_rx_if.sv - serial line and parallel word bundle for dsrlzr_rx
interface dsrlzr_rx_if #(
    parameter int WIDTH = 4
);
    logic             z;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             par_err;
    logic             frame_err;
    logic             busy;

    modport master (
        output z,
        input  y, valid, par_err, frame_err, busy
    );

    modport slave (
        input  z,
        output y, valid, par_err, frame_err, busy
    );
endinterface

// File: rtl/dsrlzr_rx.sv
// rtl/dsrlzr_rx.sv - start/data/parity/stop serial deserializer, one bit per clock
module dsrlzr_rx #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 0
) (
    input  logic         clk,
    input  logic         rst,
    dsrlzr_rx_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             pbit, pbit_next;
    logic [WIDTH-1:0] y_q, y_next;
    logic             valid_q, valid_next;
    logic             par_err_q, par_err_next;
    logic             frame_err_q, frame_err_next;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            pbit        <= 1'b0;
            y_q         <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            shreg       <= shreg_next;
            pbit        <= pbit_next;
            y_q         <= y_next;
            valid_q     <= valid_next;
            par_err_q   <= par_err_next;
            frame_err_q <= frame_err_next;
            busy_q      <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        shreg_next     = shreg;
        pbit_next      = pbit;
        y_next         = y_q;
        valid_next     = 1'b0;
        par_err_next   = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.z) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end
            end
            DATA: begin
                // MSB arrives first, so left-shifting lands it in y[WIDTH-1]
                shreg_next = {shreg[WIDTH-2:0], bus.z};
                cnt_next   = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1))
                    state_next = (PARITY_EN != 0) ? PAR : STOP;
            end
            PAR: begin
                pbit_next  = bus.z;
                state_next = STOP;
            end
            STOP: begin
                if (bus.z) begin
                    y_next       = shreg;
                    valid_next   = 1'b1;
                    par_err_next = (PARITY_EN != 0) ? ((^shreg) ^ pbit) : 1'b0;
                end else begin
                    frame_err_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.y         = y_q;
    assign bus.valid     = valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dsrlzr_rx.sv
// tb/tb_dsrlzr_rx.sv - self-checking bench for dsrlzr_rx, with and without parity
module tb_dsrlzr_rx;
    localparam int W = 4;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dsrlzr_rx_if #(.WIDTH(W)) bus0 ();
    dsrlzr_rx_if #(.WIDTH(W)) bus1 ();

    dsrlzr_rx #(.WIDTH(W), .PARITY_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    dsrlzr_rx #(.WIDTH(W), .PARITY_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    bit q0[$];
    bit q1[$];

    // expected outputs right after each clock edge, per DUT (0: no parity, 1: parity)
    bit         ev [2][N];
    bit         ep [2][N];
    bit         ef [2][N];
    bit         eb [2][N];
    logic [W-1:0] ey [2][N];
    logic [W-1:0] my [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic push_bit(input int d, input bit b);
        if (d == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Frame of start + data (MSB first) + optional parity + stop; start sampled at edge s,
    // stop sampled at edge s+L, so the result is visible just after edge s+L.
    task automatic send(input int d, input logic [W-1:0] data, input bit pbit, input bit stop);
        int s, l;
        l = W + 1 + d;
        s = edge_n + ((d == 0) ? q0.size() : q1.size());
        if (s + l >= N) begin
            compared++;
            mismatched++;
            $error("FAIL sched_overflow edge %0d: got %0d expected <%0d", edge_n, s + l, N);
        end else begin
            push_bit(d, 1'b0);
            for (int i = W - 1; i >= 0; i--) push_bit(d, data[i]);
            if (d == 1) push_bit(d, pbit);
            push_bit(d, stop);
            for (int k = s; k < s + l; k++) eb[d][k] = 1'b1;
            if (stop) begin
                ev[d][s + l] = 1'b1;
                ey[d][s + l] = data;
                ep[d][s + l] = (d == 1) && ((^data) != pbit);
            end else begin
                ef[d][s + l] = 1'b1;
            end
        end
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) push_bit(d, 1'b1);
    endtask

    task automatic tick(input bit r);
        rst    = r;
        bus0.z = (q0.size() != 0) ? q0.pop_front() : 1'b1;
        bus1.z = (q1.size() != 0) ? q1.pop_front() : 1'b1;
        @(posedge clk);
        #1;
        if (r) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                for (int k = edge_n; k < N; k++) begin
                    ev[d][k] = 1'b0; ep[d][k] = 1'b0; ef[d][k] = 1'b0; eb[d][k] = 1'b0;
                end
                my[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++)
                if (ev[d][edge_n]) my[d] = ey[d][edge_n];
        end
        chk("valid0",     bus0.valid,     ev[0][edge_n]);
        chk("par_err0",   bus0.par_err,   ep[0][edge_n]);
        chk("frame_err0", bus0.frame_err, ef[0][edge_n]);
        chk("busy0",      bus0.busy,      eb[0][edge_n]);
        chk("y0",         bus0.y,         my[0]);
        chk("valid1",     bus1.valid,     ev[1][edge_n]);
        chk("par_err1",   bus1.par_err,   ep[1][edge_n]);
        chk("frame_err1", bus1.frame_err, ef[1][edge_n]);
        chk("busy1",      bus1.busy,      eb[1][edge_n]);
        chk("y1",         bus1.y,         my[1]);
        edge_n++;
    endtask

    task automatic drain();
        while (q0.size() != 0 || q1.size() != 0) tick(1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0);
    endtask

    initial begin
        bus0.z = 1'b1;
        bus1.z = 1'b1;
        my[0]  = '0;
        my[1]  = '0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) ey[d][k] = '0;

        // reset, then idle line
        tick(1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0);

        // single frame 1011
        send(0, 4'b1011, 1'b0, 1'b1);
        drain();

        // back-to-back frames with no idle gap
        send(0, 4'b1100, 1'b0, 1'b1);
        send(0, 4'b0011, 1'b0, 1'b1);
        drain();

        // bad stop bit, followed at once by a new start bit
        send(0, 4'b0110, 1'b0, 1'b0);
        send(0, 4'b0101, 1'b0, 1'b1);
        drain();

        // reset after two data bits aborts the frame silently
        send(0, 4'b1111, 1'b0, 1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        send(0, 4'b1001, 1'b0, 1'b1);
        drain();

        // even parity good then bad
        send(1, 4'b1010, 1'b0, 1'b1);
        send(1, 4'b1010, 1'b1, 1'b1);
        drain();

        // random frames, gaps and stop/parity errors on both instances
        for (int i = 0; i < 150; i++) begin
            for (int d = 0; d < 2; d++) begin
                idle(d, $urandom_range(0, 2));
                send(d, W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) != 0));
            end
            if (i % 10 == 9) drain();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
